vga_scan_out: RTL and testbench



---
 rtl/vga_scan_out.sv | 198 +++++++++++++++++++
 tb/tb_vga_scan_out.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 raster counters, PPU latency alignment of sync/blank,
// registered RGB drive of the VGA DAC and a per-frame vertical-blank strobe.
// Optional build macro VGA_TEST_PATTERN_EN: with test_mode=1 the active colour
// becomes eight vertical colour bars instead of rgb_in.
module vga_scan_out #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIPE_DLY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] rgb_in,
   input  logic        test_mode,
   output logic [9:0]  hcount,
   output logic [9:0]  vcount,
   output logic        frame_start,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_n,
   output logic        VGA_SYNC_n,
   output logic        VGA_CLK
);

   localparam int unsigned CW      = 10;
   localparam int unsigned RGBW    = 24;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BARW  = 3;
   localparam int unsigned BAR_W = H_ACTIVE / 8;
   localparam int unsigned TW    = 3 + BARW;
`else
   localparam int unsigned TW    = 3;
`endif

   // Delay-line idle content: syncs inactive, blanked
   localparam logic [TW-1:0] TAP_RST = TW'(3'b110);

   logic            pix_en_q;
   logic [CW-1:0]   hcount_q, hcount_d;
   logic [CW-1:0]   vcount_q, vcount_d;
   logic            frame_start_q, frame_start_d;
   logic            hs_q, hs_d;
   logic            vs_q, vs_d;
   logic            blank_n_q, blank_n_d;
   logic [RGBW-1:0] rgb_q, rgb_d;

   logic            hs_c, vs_c, active_c;
   logic [TW-1:0]   tap_c, dly_c;
   logic [RGBW-1:0] colour_c;

   // Raster counters and frame strobe, advancing on pixel ticks only
   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_start_d = 1'b0;
      if (pix_en_q) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
         end else begin
            hcount_d = hcount_q + CW'(1);
         end
         frame_start_d = (hcount_d == '0) && (vcount_d == V_ACT_C);
      end
   end

   // Raw timing decoded from the presented counters
   always_comb begin
      active_c = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
      hs_c     = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
      vs_c     = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [BARW-1:0] bar_c;

   // Colour-bar index of the presented column (BAR_W pixels per bar)
   always_comb begin
      bar_c = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (hcount_q >= CW'(k * BAR_W)) bar_c = BARW'(k);
      end
   end

   function automatic logic [RGBW-1:0] bar_colour(input logic [BARW-1:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   assign tap_c    = {bar_c, hs_c, vs_c, active_c};
   assign colour_c = test_mode ? bar_colour(dly_c[5:3]) : rgb_in;
`else
   logic unused_test_mode;

   assign unused_test_mode = test_mode;
   assign tap_c            = {hs_c, vs_c, active_c};
   assign colour_c         = rgb_in;
`endif

   // Align sync/blank with the PPU colour latency
   generate
      if (PIPE_DLY == 0) begin : g_direct
         assign dly_c = tap_c;
      end else begin : g_pipe
         logic [TW-1:0] pipe_q [PIPE_DLY];

         // Shift register stepping on pixel ticks
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int unsigned i = 0; i < PIPE_DLY; i++) pipe_q[i] <= TAP_RST;
            end else if (pix_en_q) begin
               pipe_q[0] <= tap_c;
               for (int unsigned i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign dly_c = pipe_q[PIPE_DLY-1];
      end
   endgenerate

   // Output register next-state: pins update on pixel ticks
   always_comb begin
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
      rgb_d     = rgb_q;
      if (pix_en_q) begin
         hs_d      = dly_c[2];
         vs_d      = dly_c[1];
         blank_n_d = dly_c[0];
         rgb_d     = dly_c[0] ? colour_c : '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_en_q      <= 1'b0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         frame_start_q <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         rgb_q         <= '0;
      end else begin
         pix_en_q      <= !pix_en_q;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_start_q <= frame_start_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         rgb_q         <= rgb_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign frame_start = frame_start_q;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_n = blank_n_q;
   assign VGA_SYNC_n  = 1'b0;
   assign VGA_CLK     = pix_en_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full 640x480 geometry for line timing and colour
// alignment, plus a shrunken geometry (24x10 total) for frame-level behaviour.
module tb_vga_scan_out;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [23:0] rgb_full = 24'h0;
   logic [23:0] rgb_small = 24'h0;
   logic        tm_full = 1'b0;
   logic        tm_small = 1'b0;

   logic [9:0]  f_hc, f_vc, s_hc, s_vc;
   logic        f_fs, f_hs, f_vs, f_bn, f_sync, f_vclk;
   logic        s_fs, s_hs, s_vs, s_bn, s_sync, s_vclk;
   logic [7:0]  f_r, f_g, f_b, s_r, s_g, s_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   vga_scan_out u_full (
      .clk(clk), .reset(reset), .rgb_in(rgb_full), .test_mode(tm_full),
      .hcount(f_hc), .vcount(f_vc), .frame_start(f_fs),
      .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_HS(f_hs), .VGA_VS(f_vs),
      .VGA_BLANK_n(f_bn), .VGA_SYNC_n(f_sync), .VGA_CLK(f_vclk)
   );

   vga_scan_out #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(2)
   ) u_small (
      .clk(clk), .reset(reset), .rgb_in(rgb_small), .test_mode(tm_small),
      .hcount(s_hc), .vcount(s_vc), .frame_start(s_fs),
      .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
      .VGA_BLANK_n(s_bn), .VGA_SYNC_n(s_sync), .VGA_CLK(s_vclk)
   );

   function automatic logic [23:0] col_rgb(input int h);
      return {8'(h), 8'(h >> 2) ^ 8'h5A, 8'(h >> 8) ^ 8'hC3};
   endfunction

   // Pulse reset, release on a falling edge: state after 0 rising edges
   task automatic restart();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [48:0] exp_v;
      reset     = 1'b0;
      rgb_full  = 24'h123456;
      rgb_small = 24'h123456;
      exp_v     = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0};
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if ({f_hc, f_vc, f_hs, f_vs, f_bn, f_r, f_g, f_b, f_fs, f_vclk, f_sync} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_full got=%h exp=%h",
                     {f_hc, f_vc, f_hs, f_vs, f_bn, f_r, f_g, f_b, f_fs, f_vclk, f_sync}, exp_v);
         end
         n_checks++;
         if ({s_hc, s_vc, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs, s_vclk, s_sync} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_small got=%h exp=%h",
                     {s_hc, s_vc, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs, s_vclk, s_sync}, exp_v);
         end
      end
   endtask

   // Full geometry: counters, HS timing, blank and column-accurate colour
   task automatic test_raster();
      int col, h, v;
      logic exp_hs, exp_vs, exp_bn;
      logic [23:0] exp_rgb;
      rgb_full = 24'h0;
      restart();
      for (int k = 0; k <= 3300; k++) begin
         n_checks++;
         if (f_hc !== 10'((k / 2) % 800) || f_vc !== 10'(k / 1600) ||
             f_vclk !== 1'(k % 2) || f_fs !== 1'b0) begin
            n_fail++;
            $display("FAIL raster_counters k=%0d got h=%0d v=%0d clk=%b fs=%b exp h=%0d v=%0d clk=%0d fs=0",
                     k, f_hc, f_vc, f_vclk, f_fs, (k / 2) % 800, k / 1600, k % 2);
         end
         if (k >= 6) begin
            col     = (k - 6) / 2;
            h       = col % 800;
            v       = col / 800;
            exp_hs  = !(h >= 656 && h < 752);
            exp_vs  = !(v >= 490 && v < 492);
            exp_bn  = (h < 640) && (v < 480);
            exp_rgb = exp_bn ? col_rgb(h) : 24'h0;
         end else begin
            exp_hs = 1'b1; exp_vs = 1'b1; exp_bn = 1'b0; exp_rgb = 24'h0;
         end
         n_checks++;
         if ({f_hs, f_vs, f_bn, f_r, f_g, f_b} !== {exp_hs, exp_vs, exp_bn, exp_rgb}) begin
            n_fail++;
            $display("FAIL raster_pins k=%0d got hs=%b vs=%b bn=%b rgb=%h exp hs=%b vs=%b bn=%b rgb=%h",
                     k, f_hs, f_vs, f_bn, {f_r, f_g, f_b}, exp_hs, exp_vs, exp_bn, exp_rgb);
         end
         if (k >= 5) rgb_full = col_rgb(((k - 5) / 2) % 800);
         @(negedge clk);
      end
   endtask

   // Small geometry: vertical timing, frame strobe, constant colour gating
   task automatic test_frame();
      int col, h, v, pulses, bn_cnt;
      logic exp_hs, exp_vs, exp_bn, exp_fs;
      logic [23:0] exp_rgb;
      pulses = 0;
      bn_cnt = 0;
      rgb_small = 24'h9290ff;
      restart();
      for (int k = 0; k <= 1500; k++) begin
         exp_fs = (k % 480) == 288;
         n_checks++;
         if (s_hc !== 10'((k / 2) % 24) || s_vc !== 10'((k / 48) % 10) || s_fs !== exp_fs) begin
            n_fail++;
            $display("FAIL frame_counters k=%0d got h=%0d v=%0d fs=%b exp h=%0d v=%0d fs=%b",
                     k, s_hc, s_vc, s_fs, (k / 2) % 24, (k / 48) % 10, exp_fs);
         end
         if (s_fs === 1'b1) pulses++;
         if (k >= 6) begin
            col     = (k - 6) / 2;
            h       = col % 24;
            v       = (col / 24) % 10;
            exp_hs  = !(h >= 18 && h < 22);
            exp_vs  = !(v >= 7 && v < 9);
            exp_bn  = (h < 16) && (v < 6);
            exp_rgb = exp_bn ? 24'h9290ff : 24'h0;
         end else begin
            exp_hs = 1'b1; exp_vs = 1'b1; exp_bn = 1'b0; exp_rgb = 24'h0;
         end
         if (k >= 6 && k < 486 && s_bn === 1'b1) bn_cnt++;
         n_checks++;
         if ({s_hs, s_vs, s_bn, s_r, s_g, s_b} !== {exp_hs, exp_vs, exp_bn, exp_rgb}) begin
            n_fail++;
            $display("FAIL frame_pins k=%0d got hs=%b vs=%b bn=%b rgb=%h exp hs=%b vs=%b bn=%b rgb=%h",
                     k, s_hs, s_vs, s_bn, {s_r, s_g, s_b}, exp_hs, exp_vs, exp_bn, exp_rgb);
         end
         @(negedge clk);
      end
      n_checks++;
      if (pulses !== 3) begin
         n_fail++;
         $display("FAIL frame_start_count got=%0d exp=3", pulses);
      end
      n_checks++;
      if (bn_cnt !== 192) begin
         n_fail++;
         $display("FAIL blank_active_clks got=%0d exp=192", bn_cnt);
      end
   endtask

   // Reset asserted mid-frame, then counting restarts from (0,0)
   task automatic test_mid_reset();
      logic [48:0] exp_v;
      int col, h, v;
      logic exp_bn;
      exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0};
      rgb_small = 24'h9290ff;
      restart();
      repeat (164) @(negedge clk);
      n_checks++;
      if (s_hc !== 10'd10 || s_vc !== 10'd3 || f_hc !== 10'd82 || s_bn !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre got sh=%0d sv=%0d fh=%0d bn=%b exp sh=10 sv=3 fh=82 bn=1",
                  s_hc, s_vc, f_hc, s_bn);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({s_hc, s_vc, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs, s_vclk, s_sync} !== exp_v ||
          f_hc !== 10'd0 || f_bn !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async got=%h fh=%0d fbn=%b exp=%h fh=0 fbn=0",
                  {s_hc, s_vc, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs, s_vclk, s_sync}, f_hc, f_bn, exp_v);
      end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if ({s_hc, s_vc, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs, s_vclk, s_sync} !== exp_v) begin
            n_fail++;
            $display("FAIL midreset_hold got=%h exp=%h",
                     {s_hc, s_vc, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs, s_vclk, s_sync}, exp_v);
         end
      end
      reset = 1'b1;
      for (int k = 0; k <= 600; k++) begin
         if (k >= 6) begin
            col    = (k - 6) / 2;
            h      = col % 24;
            v      = (col / 24) % 10;
            exp_bn = (h < 16) && (v < 6);
         end else begin
            exp_bn = 1'b0;
         end
         n_checks++;
         if (s_hc !== 10'((k / 2) % 24) || s_vc !== 10'((k / 48) % 10) || s_bn !== exp_bn ||
             s_fs !== ((k % 480) == 288)) begin
            n_fail++;
            $display("FAIL midreset_resume k=%0d got h=%0d v=%0d bn=%b fs=%b exp h=%0d v=%0d bn=%b",
                     k, s_hc, s_vc, s_bn, s_fs, (k / 2) % 24, (k / 48) % 10, exp_bn);
         end
         @(negedge clk);
      end
   endtask

`ifdef VGA_TEST_PATTERN_EN
   // Colour bars replace rgb_in while test_mode is high
   task automatic test_pattern();
      logic [23:0] bars [8];
      logic [23:0] exp_rgb;
      int h;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      tm_full  = 1'b1;
      rgb_full = 24'h123456;
      restart();
      for (int k = 0; k <= 1700; k++) begin
         h = ((k - 6) / 2) % 800;
         exp_rgb = (k >= 6 && h < 640) ? bars[h / 80] : 24'h0;
         n_checks++;
         if ({f_r, f_g, f_b} !== exp_rgb) begin
            n_fail++;
            $display("FAIL pattern k=%0d col=%0d got=%h exp=%h", k, h, {f_r, f_g, f_b}, exp_rgb);
         end
         @(negedge clk);
      end
      tm_full = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_raster();
      test_frame();
      test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
